// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and byte-merge helper for the data-memory write buffer
package mips_pkg;
  localparam int AW_DEF = 8;
  localparam int DW = 32;
  localparam int BEW = DW / 8;
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w, input logic [BEW-1:0] be);
    merge_bytes = old_w;
    for (int b = 0; b < BEW; b++) if (be[b]) merge_bytes[8*b+:8] = new_w[8*b+:8];
  endfunction
endpackage

// File: rtl/wbuf_fwd_merge.sv
// wbuf_fwd_merge: per-lane youngest-match forwarding and coalesce-hit lookup
//   i_valid/i_addr/i_data/i_be : write-buffer entry arrays
//   i_head                     : oldest entry index
//   i_drain                    : head is draining this cycle (excluded from coalescing)
//   i_daddr, i_ram_word        : lookup address and RAM word at that address
//   o_rdata                    : RAM word overlaid with youngest buffered bytes
//   o_hit, o_hit_idx           : non-draining entry matching i_daddr
module wbuf_fwd_merge
  import mips_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]          i_valid,
  input  logic [DEPTH-1:0][AW-1:0]  i_addr,
  input  logic [DEPTH-1:0][DW-1:0]  i_data,
  input  logic [DEPTH-1:0][BEW-1:0] i_be,
  input  logic [PW-1:0]             i_head,
  input  logic                      i_drain,
  input  logic [AW-1:0]             i_daddr,
  input  logic [DW-1:0]             i_ram_word,
  output logic [DW-1:0]             o_rdata,
  output logic                      o_hit,
  output logic [PW-1:0]             o_hit_idx
);
  logic [PW-1:0] w_idx;
  // walk oldest to youngest so younger matches overwrite older ones
  always_comb begin
    o_rdata = i_ram_word;
    o_hit = 1'b0;
    o_hit_idx = '0;
    w_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_head + PW'(k);
      if (i_valid[w_idx] && i_addr[w_idx] == i_daddr) begin
        o_rdata = merge_bytes(o_rdata, i_data[w_idx], i_be[w_idx]);
        if (!(i_drain && w_idx == i_head)) begin
          o_hit = 1'b1;
          o_hit_idx = w_idx;
        end
      end
    end
  end
endmodule

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: 2**AW x 32 data RAM behind a coalescing posted write buffer
//   clk, nrst        : clock, async active-low reset
//   daddr/wdata/wr   : core word address, store data, byte-lane enables (wr!=0 = store)
//   rd               : load request; buffer drains only when rd==0
//   rdata            : combinational load data with store forwarding
//   stall            : store to a new address with the buffer full
//   occ, empty       : buffer occupancy
module dmem_wbuf
  import mips_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] wdata,
  input  logic [3:0]    wr,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic          stall,
  output logic [PW:0]   occ,
  output logic          empty
);
  logic [DW-1:0]             r_ram [2**AW];
  logic [DEPTH-1:0]          r_valid;
  logic [DEPTH-1:0][AW-1:0]  r_addr;
  logic [DEPTH-1:0][DW-1:0]  r_data;
  logic [DEPTH-1:0][BEW-1:0] r_be;
  logic [PW-1:0]             r_head, r_tail;
  logic [PW:0]               r_occ;
  logic                      w_store, w_drain, w_full, w_hit, w_alloc;
  logic [PW-1:0]             w_hit_idx;
  assign w_store = |wr;
  assign w_drain = !rd && r_occ != '0;
  assign w_full = r_occ == (PW+1)'(DEPTH);
  assign w_alloc = w_store && !w_hit && !w_full;
  assign stall = w_store && !w_hit && w_full;
  assign occ = r_occ;
  assign empty = r_occ == '0;
  wbuf_fwd_merge #(.AW(AW), .DEPTH(DEPTH)) u_fwd (
    .i_valid(r_valid),
    .i_addr(r_addr),
    .i_data(r_data),
    .i_be(r_be),
    .i_head(r_head),
    .i_drain(w_drain),
    .i_daddr(daddr),
    .i_ram_word(r_ram[daddr]),
    .o_rdata(rdata),
    .o_hit(w_hit),
    .o_hit_idx(w_hit_idx)
  );
  // RAM is not reset; reset empties the buffer so no drain write is pending
  always_ff @(posedge clk) begin
    if (w_drain) r_ram[r_addr[r_head]] <= merge_bytes(r_ram[r_addr[r_head]], r_data[r_head], r_be[r_head]);
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_valid <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_be <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_occ <= '0;
    end else begin
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail] <= daddr;
        r_data[r_tail] <= wdata;
        r_be[r_tail] <= wr;
        r_tail <= r_tail + 1'b1;
      end
      if (w_store && w_hit) begin
        r_data[w_hit_idx] <= merge_bytes(r_data[w_hit_idx], wdata, wr);
        r_be[w_hit_idx] <= r_be[w_hit_idx] | wr;
      end
      r_occ <= r_occ + (PW+1)'(w_alloc) - (PW+1)'(w_drain);
    end
  end
endmodule

// File: tb/tb_dmem_wbuf.sv
// tb_dmem_wbuf: directed self-checking bench for dmem_wbuf
module tb_dmem_wbuf;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [7:0]  daddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wr = '0;
  logic        rd = 1'b0;
  logic [31:0] rdata;
  logic        stall;
  logic [2:0]  occ;
  logic        empty;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  dmem_wbuf #(.AW(8), .DEPTH(4)) dut (
    .clk(clk),
    .nrst(nrst),
    .daddr(daddr),
    .wdata(wdata),
    .wr(wr),
    .rd(rd),
    .rdata(rdata),
    .stall(stall),
    .occ(occ),
    .empty(empty)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [7:0] a, input logic [31:0] d, input logic [3:0] w, input logic r);
    daddr = a;
    wdata = d;
    wr = w;
    rd = r;
    #2;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    step(a, d, 4'hF, 1'b0);
    tick();
    step(8'h00, '0, 4'h0, 1'b0);
    tick();
  endtask
  initial begin
    tick();
    tick();
    nrst = 1'b1;
    step(8'h00, '0, 4'h0, 1'b0);
    chk("rst_occ", 32'(occ), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    preload(8'h10, 32'hDEADBEEF);
    step(8'h10, '0, 4'h0, 1'b1);
    chk("load_10", rdata, 32'hDEADBEEF);
    step(8'h05, 32'h11223344, 4'hF, 1'b0);
    tick();
    chk("st05_occ", 32'(occ), 32'd1);
    step(8'h05, '0, 4'h0, 1'b1);
    chk("fwd_05", rdata, 32'h11223344);
    tick();
    step(8'h00, '0, 4'h0, 1'b0);
    tick();
    chk("drain05_occ", 32'(occ), 32'd0);
    step(8'h05, '0, 4'h0, 1'b1);
    chk("ram_05", rdata, 32'h11223344);
    preload(8'h07, 32'hAABBCCDD);
    step(8'h07, 32'h000000EE, 4'b0001, 1'b1);
    tick();
    step(8'h07, 32'h00990000, 4'b0100, 1'b1);
    chk("coal_stall", 32'(stall), 32'd0);
    tick();
    chk("coal_occ", 32'(occ), 32'd1);
    step(8'h07, '0, 4'h0, 1'b1);
    chk("coal_fwd", rdata, 32'hAA99CCEE);
    step(8'h00, '0, 4'h0, 1'b0);
    tick();
    step(8'h07, '0, 4'h0, 1'b1);
    chk("coal_ram", rdata, 32'hAA99CCEE);
    for (int i = 0; i < 4; i++) begin
      step(8'h20 + 8'(i), {4{8'h20 + 8'(i)}}, 4'hF, 1'b1);
      tick();
    end
    chk("full_occ", 32'(occ), 32'd4);
    chk("full_empty", 32'(empty), 32'd0);
    step(8'h24, 32'h24242424, 4'hF, 1'b1);
    chk("full_stall", 32'(stall), 32'd1);
    tick();
    chk("full_hold_occ", 32'(occ), 32'd4);
    step(8'h21, 32'h0000AB00, 4'b0010, 1'b1);
    chk("full_coal_stall", 32'(stall), 32'd0);
    tick();
    chk("full_coal_occ", 32'(occ), 32'd4);
    step(8'h21, '0, 4'h0, 1'b1);
    chk("full_coal_fwd", rdata, 32'h2121AB21);
    for (int i = 3; i >= 0; i--) begin
      step(8'h00, '0, 4'h0, 1'b0);
      tick();
      chk($sformatf("drain_occ%0d", i), 32'(occ), 32'(i));
    end
    step(8'h20, '0, 4'h0, 1'b1);
    chk("ram_20", rdata, 32'h20202020);
    step(8'h21, '0, 4'h0, 1'b1);
    chk("ram_21", rdata, 32'h2121AB21);
    preload(8'h32, 32'h0BADF00D);
    for (int i = 0; i < 4; i++) begin
      step(8'h30 + 8'(i), {4{8'h30 + 8'(i)}}, 4'hF, 1'b1);
      tick();
    end
    step(8'h34, 32'h34343434, 4'hF, 1'b0);
    chk("fulldrain_stall", 32'(stall), 32'd1);
    tick();
    chk("fulldrain_occ", 32'(occ), 32'd3);
    step(8'h34, 32'h34343434, 4'hF, 1'b1);
    chk("retry_stall", 32'(stall), 32'd0);
    tick();
    chk("retry_occ", 32'(occ), 32'd4);
    step(8'h00, '0, 4'h0, 1'b0);
    tick();
    chk("pre_rst_occ", 32'(occ), 32'd3);
    nrst = 1'b0;
    #1;
    chk("arst_occ", 32'(occ), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    tick();
    nrst = 1'b1;
    step(8'h30, '0, 4'h0, 1'b1);
    chk("arst_ram30", rdata, 32'h30303030);
    step(8'h31, '0, 4'h0, 1'b1);
    chk("arst_ram31", rdata, 32'h31313131);
    step(8'h32, '0, 4'h0, 1'b1);
    chk("arst_ram32", rdata, 32'h0BADF00D);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
